pipeline_ctrl: RTL and testbench

- Central sequencing controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
- Resolves load-use stalls, branch/jump redirects and the syscall halt/resume handshake with the `go` button.
- Drives the PC mux select, PC enable and the per-stage enable/flush of the pipeline registers.
- Owns the performance counters shown on the board display.

---
 rtl/pipeline_ctrl_if.sv | 40 ++++
 rtl/pipeline_ctrl.sv | 123 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_if.sv
// Control bundle between the pipeline datapath and its sequencing controller.
// The datapath side is the master; the controller is the slave.
interface pipeline_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             go;
    logic             load_use;
    logic             branch_taken;
    logic             jump_id;
    logic             jr_id;
    logic             halt_id;

    logic             pc_enable;
    logic [1:0]       pc_sel;
    logic             if_id_enable;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_mem_enable;
    logic             mem_wb_enable;
    logic             halted;
    logic             led_cpu_enable;
    logic [CNT_W-1:0] total_cycles;
    logic [CNT_W-1:0] condi_branch_num;
    logic [CNT_W-1:0] uncondi_branch_num;
    logic [CNT_W-1:0] bubble_num;

    modport master (
        output go, load_use, branch_taken, jump_id, jr_id, halt_id,
        input  pc_enable, pc_sel, if_id_enable, if_id_flush, id_ex_flush,
               ex_mem_enable, mem_wb_enable, halted, led_cpu_enable,
               total_cycles, condi_branch_num, uncondi_branch_num, bubble_num
    );

    modport slave (
        input  go, load_use, branch_taken, jump_id, jr_id, halt_id,
        output pc_enable, pc_sel, if_id_enable, if_id_flush, id_ex_flush,
               ex_mem_enable, mem_wb_enable, halted, led_cpu_enable,
               total_cycles, condi_branch_num, uncondi_branch_num, bubble_num
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Sequencing controller for the 5-stage pipeline: stalls, redirects, syscall
// halt/resume via the go button, and the board performance counters.
module pipeline_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    pipeline_ctrl_if.slave bus
);
    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_HALT    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic             r_go_q;
    logic [CNT_W-1:0] r_total_cycles;
    logic [CNT_W-1:0] r_condi_branch_num;
    logic [CNT_W-1:0] r_uncondi_branch_num;
    logic [CNT_W-1:0] r_bubble_num;

    logic [1:0] w_next_state;
    logic       w_go_rise;
    logic       w_pc_enable;
    logic [1:0] w_pc_sel;
    logic       w_if_id_enable;
    logic       w_if_id_flush;
    logic       w_id_ex_flush;
    logic       w_inc_condi;
    logic       w_inc_uncondi;
    logic       w_inc_bubble;
    logic       w_halted;

    assign w_go_rise = bus.go & ~r_go_q;
    assign w_halted  = rst & (r_state == ST_HALT);

    always_comb begin
        w_next_state   = ST_RUN;
        w_pc_enable    = 1'b1;
        w_pc_sel       = 2'b00;
        w_if_id_enable = 1'b1;
        w_if_id_flush  = 1'b0;
        w_id_ex_flush  = 1'b0;
        w_inc_condi    = 1'b0;
        w_inc_uncondi  = 1'b0;
        w_inc_bubble   = 1'b0;

        if (r_state == ST_HALT) begin
            w_pc_enable    = 1'b0;
            w_if_id_enable = 1'b0;
            w_id_ex_flush  = 1'b1;
            w_next_state   = w_go_rise ? ST_RELEASE : ST_HALT;
        end else if (bus.branch_taken) begin
            // The ID instruction is wrong-path, so everything decoded there is dropped.
            w_pc_sel      = 2'b01;
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
            w_inc_condi   = 1'b1;
        end else if (bus.load_use) begin
            // Checked ahead of jumps so a JR never reads an unforwarded operand.
            w_pc_enable    = 1'b0;
            w_if_id_enable = 1'b0;
            w_id_ex_flush  = 1'b1;
            w_inc_bubble   = 1'b1;
            w_next_state   = (r_state == ST_RELEASE) ? ST_RELEASE : ST_RUN;
        end else if (bus.jr_id || bus.jump_id) begin
            w_pc_sel      = bus.jr_id ? 2'b11 : 2'b10;
            w_if_id_flush = 1'b1;
            w_inc_uncondi = 1'b1;
        end else if (bus.halt_id && (r_state == ST_RUN)) begin
            w_pc_enable    = 1'b0;
            w_if_id_enable = 1'b0;
            w_id_ex_flush  = 1'b1;
            w_next_state   = ST_HALT;
        end

        if (!rst) begin
            w_pc_enable    = 1'b0;
            w_pc_sel       = 2'b00;
            w_if_id_enable = 1'b1;
            w_if_id_flush  = 1'b1;
            w_id_ex_flush  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state              <= ST_RUN;
            r_go_q               <= 1'b0;
            r_total_cycles       <= '0;
            r_condi_branch_num   <= '0;
            r_uncondi_branch_num <= '0;
            r_bubble_num         <= '0;
        end else begin
            r_state <= w_next_state;
            r_go_q  <= bus.go;
            if (r_state != ST_HALT)
                r_total_cycles <= r_total_cycles + CNT_ONE;
            if (w_inc_condi)
                r_condi_branch_num <= r_condi_branch_num + CNT_ONE;
            if (w_inc_uncondi)
                r_uncondi_branch_num <= r_uncondi_branch_num + CNT_ONE;
            if (w_inc_bubble)
                r_bubble_num <= r_bubble_num + CNT_ONE;
        end
    end

    // Older instructions keep draining through EX/MEM/WB during stalls and halt.
    assign bus.ex_mem_enable      = 1'b1;
    assign bus.mem_wb_enable      = 1'b1;
    assign bus.pc_enable          = w_pc_enable;
    assign bus.pc_sel             = w_pc_sel;
    assign bus.if_id_enable       = w_if_id_enable;
    assign bus.if_id_flush        = w_if_id_flush;
    assign bus.id_ex_flush        = w_id_ex_flush;
    assign bus.halted             = w_halted;
    assign bus.led_cpu_enable     = w_halted;
    assign bus.total_cycles       = r_total_cycles;
    assign bus.condi_branch_num   = r_condi_branch_num;
    assign bus.uncondi_branch_num = r_uncondi_branch_num;
    assign bus.bubble_num         = r_bubble_num;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios pinned by literals, then
// randomized traffic compared every cycle against a behavioural model.
module tb_pipeline_ctrl;
    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();
    pipeline_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: mode flags plus plain counters.
    bit               m_halted  = 1'b0;
    bit               m_release = 1'b0;
    bit               m_go_prev = 1'b0;
    logic [CNT_W-1:0] m_total = '0, m_condi = '0, m_uncondi = '0, m_bubble = '0;

    // outs = {pc_enable, pc_sel[1:0], if_id_enable, if_id_flush, id_ex_flush,
    //         ex_mem_enable, mem_wb_enable, halted, led_cpu_enable}
    typedef struct packed {
        logic [9:0] outs;
        logic       br;
        logic       jmp;
        logic       stall;
        logic       halt;
    } mres_t;

    function automatic mres_t model_eval(bit in_rst, bit halted, bit releasing,
                                         bit br, bit ld, bit j, bit jr, bit h);
        mres_t r;
        r = '0;
        if (in_rst)       r.outs = 10'b0_00_1_1_1_1_1_0_0;
        else if (halted)  r.outs = 10'b0_00_0_0_1_1_1_1_1;
        else if (br) begin
            r.br = 1'b1;  r.outs = 10'b1_01_1_1_1_1_1_0_0;
        end else if (ld) begin
            r.stall = 1'b1; r.outs = 10'b0_00_0_0_1_1_1_0_0;
        end else if (j || jr) begin
            r.jmp = 1'b1;
            r.outs = jr ? 10'b1_11_1_1_0_1_1_0_0 : 10'b1_10_1_1_0_1_1_0_0;
        end else if (h && !releasing) begin
            r.halt = 1'b1; r.outs = 10'b0_00_0_0_1_1_1_0_0;
        end else           r.outs = 10'b1_00_1_0_0_1_1_0_0;
        return r;
    endfunction

    function automatic mres_t cur_eval();
        return model_eval(!rst, m_halted, m_release, bus.branch_taken, bus.load_use,
                          bus.jump_id, bus.jr_id, bus.halt_id);
    endfunction

    always @(posedge clk) begin
        mres_t r;
        r = cur_eval();
        if (!rst) begin
            m_halted <= 1'b0; m_release <= 1'b0; m_go_prev <= 1'b0;
            m_total <= '0; m_condi <= '0; m_uncondi <= '0; m_bubble <= '0;
        end else begin
            m_go_prev <= bus.go;
            if (m_halted) begin
                if (bus.go && !m_go_prev) begin
                    m_halted  <= 1'b0;
                    m_release <= 1'b1;
                end
            end else begin
                m_total   <= m_total + 1;
                m_condi   <= m_condi + CNT_W'(r.br);
                m_uncondi <= m_uncondi + CNT_W'(r.jmp);
                m_bubble  <= m_bubble + CNT_W'(r.stall);
                m_release <= m_release && r.stall;
                m_halted  <= r.halt;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            mres_t r;
            r = cur_eval();
            chk("outputs", {54'd0, bus.pc_enable, bus.pc_sel, bus.if_id_enable, bus.if_id_flush,
                            bus.id_ex_flush, bus.ex_mem_enable, bus.mem_wb_enable, bus.halted,
                            bus.led_cpu_enable}, {54'd0, r.outs});
            chk("total_cycles", 64'(bus.total_cycles), 64'(m_total));
            chk("condi_branch_num", 64'(bus.condi_branch_num), 64'(m_condi));
            chk("uncondi_branch_num", 64'(bus.uncondi_branch_num), 64'(m_uncondi));
            chk("bubble_num", 64'(bus.bubble_num), 64'(m_bubble));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        bus.load_use = 0; bus.branch_taken = 0; bus.jump_id = 0;
        bus.jr_id = 0; bus.halt_id = 0;
    endtask

    initial begin
        logic [CNT_W-1:0] t_frozen;
        bus.go = 0;
        clr_in();
        rst = 0;
        repeat (2) tick();
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_pc_enable", 64'(bus.pc_enable), 64'd0);
        chk("rst_flushes", 64'({bus.if_id_flush, bus.id_ex_flush, bus.if_id_enable}), 64'b111);
        chk("rst_total", 64'(bus.total_cycles), 64'd0);

        tick(); rst = 1;
        @(negedge clk);
        chk("run0_pc", 64'({bus.pc_enable, bus.pc_sel}), 64'b100);
        repeat (10) tick();
        @(negedge clk);
        chk("total_after_10", 64'(bus.total_cycles), 64'd10);

        tick(); bus.load_use = 1;
        @(negedge clk);
        chk("lu_stall", 64'({bus.pc_enable, bus.if_id_enable, bus.id_ex_flush}), 64'b001);
        tick(); clr_in();
        @(negedge clk);
        chk("lu_bubble", 64'(bus.bubble_num), 64'd1);
        chk("lu_resume", 64'(bus.pc_enable), 64'd1);

        tick(); bus.branch_taken = 1; bus.jump_id = 1; bus.load_use = 1;
        @(negedge clk);
        chk("br_outs", 64'({bus.pc_sel, bus.if_id_flush, bus.id_ex_flush}), 64'b0111);
        tick(); clr_in();
        @(negedge clk);
        chk("br_condi", 64'(bus.condi_branch_num), 64'd1);
        chk("br_uncondi", 64'(bus.uncondi_branch_num), 64'd0);
        chk("br_bubble", 64'(bus.bubble_num), 64'd1);

        tick(); bus.jr_id = 1; bus.load_use = 1;
        @(negedge clk);
        chk("jr_stall", 64'(bus.pc_enable), 64'd0);
        tick(); bus.load_use = 0;
        @(negedge clk);
        chk("jr_accept", 64'({bus.pc_sel, bus.if_id_flush}), 64'b111);
        chk("jr_bubble", 64'(bus.bubble_num), 64'd2);
        chk("jr_uncondi_pre", 64'(bus.uncondi_branch_num), 64'd0);
        tick(); clr_in();
        @(negedge clk);
        chk("jr_uncondi", 64'(bus.uncondi_branch_num), 64'd1);

        tick(); bus.go = 1; bus.halt_id = 1;
        @(negedge clk);
        chk("halt_entry", 64'({bus.pc_enable, bus.id_ex_flush, bus.halted}), 64'b010);
        tick();
        @(negedge clk);
        chk("halted", 64'({bus.halted, bus.led_cpu_enable}), 64'b11);
        t_frozen = bus.total_cycles;
        repeat (3) tick();
        @(negedge clk);
        chk("held_go_no_release", 64'(bus.halted), 64'd1);
        chk("total_frozen", 64'(bus.total_cycles), 64'(t_frozen));
        tick(); bus.go = 0;
        tick(); bus.go = 1;
        @(negedge clk);
        chk("halt_at_rise", 64'(bus.halted), 64'd1);
        tick();
        @(negedge clk);
        chk("release", 64'({bus.halted, bus.pc_enable}), 64'b01);
        tick(); bus.halt_id = 0;
        @(negedge clk);
        chk("back_run", 64'({bus.halted, bus.pc_enable}), 64'b01);

        tick(); bus.go = 0; bus.halt_id = 1;
        tick(); bus.halt_id = 0;
        @(negedge clk);
        chk("halt2", 64'(bus.halted), 64'd1);
        tick(); rst = 0;
        @(negedge clk);
        chk("rst_halted_forced", 64'(bus.halted), 64'd0);
        tick(); rst = 1;
        @(negedge clk);
        chk("rst_counters", 64'({bus.total_cycles, bus.bubble_num}), 64'd0);
        chk("rst_counters2", 64'({bus.condi_branch_num, bus.uncondi_branch_num}), 64'd0);
        chk("rst_run", 64'({bus.halted, bus.pc_enable}), 64'b01);

        for (int i = 0; i < 4000; i++) begin
            tick();
            bus.load_use     = ($urandom_range(0, 4) == 0);
            bus.branch_taken = ($urandom_range(0, 5) == 0);
            bus.jump_id      = ($urandom_range(0, 7) == 0);
            bus.jr_id        = ($urandom_range(0, 7) == 0);
            bus.halt_id      = ($urandom_range(0, 6) == 0);
            if ($urandom_range(0, 3) == 0) bus.go = ~bus.go;
            rst = ($urandom_range(0, 99) != 0);
        end
        tick(); clr_in(); rst = 1;
        @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
